// File: rtl/pcie_link_seq_pkg.sv
// rtl/pcie_link_seq_pkg.sv - state encoding, default timing constants and helpers for the link sequencer
package pcie_link_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_REL_HOST  = 3'd1,
    ST_WAIT_LINK = 3'd2,
    ST_RUN       = 3'd3,
    ST_TIMEOUT   = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_HOLD_CYCLES    = 10;
  localparam int unsigned DEF_EP_DELAY       = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;
  localparam int unsigned CNT_W              = 32;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pcie_link_seq_cnt.sv
// rtl/pcie_link_seq_cnt.sv - clearable up-counter flagging the edge on which it reaches its limit
module pcie_link_seq_cnt
  import pcie_link_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // hit looks at the incremented value so the caller can act on the same edge the count lands
  assign hit = en && (cnt_inc == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pcie_link_seq.sv
// rtl/pcie_link_seq.sv - host/endpoint reset release sequencer with link-training watchdog
module pcie_link_seq
  import pcie_link_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned EP_DELAY       = DEF_EP_DELAY,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       Clk,
  input  logic       notReset,
  input  logic       SwReset,
  input  logic       HostLinkUp,
  input  logic       EpLinkUp,
  output logic       HostnReset,
  output logic       EpnReset,
  output logic       LinkUp,
  output logic       Fatal,
  output logic [7:0] LinkDropCount,
  output logic [2:0] SeqState
);

  seq_state_e state_q, state_d;
  logic       host_nreset_q, host_nreset_d;
  logic       ep_nreset_q, ep_nreset_d;
  logic       link_up_q, link_up_d;
  logic       fatal_q, fatal_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  logic             links_up;
  logic             phase_en, phase_clr, phase_hit;
  logic [CNT_W-1:0] phase_limit;
  logic             wdog_en, wdog_clr, wdog_hit;

  assign links_up = HostLinkUp && EpLinkUp;

  // One counter times both the host hold-off and the endpoint delay; it restarts on every state change
  assign phase_en    = (state_q == ST_HOLD) || (state_q == ST_REL_HOST);
  assign phase_limit = (state_q == ST_REL_HOST) ? CNT_W'(EP_DELAY) : CNT_W'(HOLD_CYCLES);
  assign phase_clr   = SwReset || (state_d != state_q);

  assign wdog_en  = (state_q == ST_REL_HOST) || (state_q == ST_WAIT_LINK);
  assign wdog_clr = SwReset
                 || ((state_q == ST_HOLD) && (state_d == ST_REL_HOST))
                 || ((state_q != ST_RUN)  && (state_d == ST_RUN))
                 || ((state_q == ST_RUN)  && (state_d == ST_WAIT_LINK));

  pcie_link_seq_cnt u_phase_cnt (
    .clk   (Clk),
    .rst_n (notReset),
    .clr   (phase_clr),
    .en    (phase_en),
    .limit (phase_limit),
    .hit   (phase_hit)
  );

  pcie_link_seq_cnt u_wdog_cnt (
    .clk   (Clk),
    .rst_n (notReset),
    .clr   (wdog_clr),
    .en    (wdog_en),
    .limit (CNT_W'(TIMEOUT_CYCLES)),
    .hit   (wdog_hit)
  );

  always_comb begin
    state_d       = state_q;
    host_nreset_d = host_nreset_q;
    ep_nreset_d   = ep_nreset_q;
    link_up_d     = link_up_q;
    fatal_d       = fatal_q;
    drop_cnt_d    = drop_cnt_q;

    if (SwReset) begin
      state_d       = ST_HOLD;
      host_nreset_d = 1'b0;
      ep_nreset_d   = 1'b0;
      link_up_d     = 1'b0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (phase_hit) begin
            state_d       = ST_REL_HOST;
            host_nreset_d = 1'b1;
          end
        end
        ST_REL_HOST: begin
          if (wdog_hit) begin
            state_d       = ST_TIMEOUT;
            fatal_d       = 1'b1;
            host_nreset_d = 1'b0;
            ep_nreset_d   = 1'b0;
            link_up_d     = 1'b0;
          end else if (phase_hit) begin
            state_d     = ST_WAIT_LINK;
            ep_nreset_d = 1'b1;
          end
        end
        ST_WAIT_LINK: begin
          // A link that trains on the expiry edge still counts as trained
          if (links_up) begin
            state_d   = ST_RUN;
            link_up_d = 1'b1;
          end else if (wdog_hit) begin
            state_d       = ST_TIMEOUT;
            fatal_d       = 1'b1;
            host_nreset_d = 1'b0;
            ep_nreset_d   = 1'b0;
            link_up_d     = 1'b0;
          end
        end
        ST_RUN: begin
          if (!links_up) begin
            state_d    = ST_WAIT_LINK;
            link_up_d  = 1'b0;
            drop_cnt_d = sat_inc8(drop_cnt_q);
          end
        end
        ST_TIMEOUT: begin
          host_nreset_d = 1'b0;
          ep_nreset_d   = 1'b0;
          link_up_d     = 1'b0;
        end
        default: begin
          state_d       = ST_HOLD;
          host_nreset_d = 1'b0;
          ep_nreset_d   = 1'b0;
          link_up_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      state_q       <= ST_HOLD;
      host_nreset_q <= 1'b0;
      ep_nreset_q   <= 1'b0;
      link_up_q     <= 1'b0;
      fatal_q       <= 1'b0;
      drop_cnt_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      host_nreset_q <= host_nreset_d;
      ep_nreset_q   <= ep_nreset_d;
      link_up_q     <= link_up_d;
      fatal_q       <= fatal_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign HostnReset    = host_nreset_q;
  assign EpnReset      = ep_nreset_q;
  assign LinkUp        = link_up_q;
  assign Fatal         = fatal_q;
  assign LinkDropCount = drop_cnt_q;
  assign SeqState      = state_q;

endmodule

// File: tb/tb_pcie_link_seq.sv
// tb/tb_pcie_link_seq.sv - scoreboard bench for the link sequencer with HOLD=4, EP_DELAY=2, TIMEOUT=20
module tb_pcie_link_seq;

  localparam int unsigned HOLD = 4;
  localparam int unsigned EPD  = 2;
  localparam int unsigned TMO  = 20;

  logic       Clk = 1'b0;
  logic       notReset = 1'b0;
  logic       SwReset = 1'b0;
  logic       HostLinkUp = 1'b0;
  logic       EpLinkUp = 1'b0;
  logic       HostnReset, EpnReset, LinkUp, Fatal;
  logic [7:0] LinkDropCount;
  logic [2:0] SeqState;

  pcie_link_seq #(
    .HOLD_CYCLES    (HOLD),
    .EP_DELAY       (EPD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clk           (Clk),
    .notReset      (notReset),
    .SwReset       (SwReset),
    .HostLinkUp    (HostLinkUp),
    .EpLinkUp      (EpLinkUp),
    .HostnReset    (HostnReset),
    .EpnReset      (EpnReset),
    .LinkUp        (LinkUp),
    .Fatal         (Fatal),
    .LinkDropCount (LinkDropCount),
    .SeqState      (SeqState)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          cyc;
    logic [14:0] vec;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc;
  int   n_checks;
  int   n_errors;

  wire [14:0] obs = {HostnReset, EpnReset, LinkUp, Fatal, LinkDropCount, SeqState};

  // {host_nreset, ep_nreset, link_up, fatal, drops[7:0], state[2:0]}
  function automatic logic [14:0] ev(bit h, bit ep, bit l, bit f, int d, int s);
    return {h, ep, l, f, 8'(d), 3'(s)};
  endfunction

  task automatic push(int c, logic [14:0] v, string t);
    sb.push_back('{c, v, t});
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic release_reset();
    @(posedge Clk);
    #1;
    notReset = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    notReset = 1'b0; SwReset = 1'b0; HostLinkUp = 1'b0; EpLinkUp = 1'b0;
    repeat (3) tick();
    push(cyc, ev(0, 0, 0, 0, 0, 0), "reset_state");
    while (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front(); n_checks++;
      if (obs !== e.vec) begin n_errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.vec); end
    end
    if (sb.size() != 0) begin n_checks++; n_errors++; $display("FAIL reset_leftover: got %0d pending expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_release();
    release_reset();
    push(3, ev(0, 0, 0, 0, 0, 0), "hold_edge3");
    push(4, ev(1, 0, 0, 0, 0, 1), "host_rel_edge4");
    push(5, ev(1, 0, 0, 0, 0, 1), "rel_host_edge5");
    push(6, ev(1, 1, 0, 0, 0, 2), "ep_rel_edge6");
    while (cyc < 6) begin
      tick();
      while (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front(); n_checks++;
        if (obs !== e.vec) begin n_errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.vec); end
      end
    end
    if (sb.size() != 0) begin n_checks++; n_errors++; $display("FAIL release_leftover: got %0d pending expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_link_up();
    push(11, ev(1, 1, 0, 0, 0, 2), "wait_link_edge11");
    push(12, ev(1, 1, 1, 0, 0, 3), "link_up_edge12");
    push(15, ev(1, 1, 1, 0, 0, 3), "run_stable_edge15");
    while (cyc < 15) begin
      if (cyc == 11) begin HostLinkUp = 1'b1; EpLinkUp = 1'b1; end
      tick();
      while (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front(); n_checks++;
        if (obs !== e.vec) begin n_errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.vec); end
      end
    end
    if (sb.size() != 0) begin n_checks++; n_errors++; $display("FAIL link_up_leftover: got %0d pending expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_drops();
    int c0 = cyc;
    for (int p = 0; p < 300; p++) begin
      int d = (p + 1 > 255) ? 255 : p + 1;
      push(c0 + 2 * p + 1, ev(1, 1, 0, 0, d, 2), $sformatf("drop_%0d", p));
      push(c0 + 2 * p + 2, ev(1, 1, 1, 0, d, 3), $sformatf("recover_%0d", p));
    end
    for (int i = 1; i <= 600; i++) begin
      EpLinkUp = (i % 2 == 0);
      tick();
      while (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front(); n_checks++;
        if (obs !== e.vec) begin n_errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.vec); end
      end
    end
    if (sb.size() != 0) begin n_checks++; n_errors++; $display("FAIL drops_leftover: got %0d pending expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_timeout();
    notReset = 1'b0; HostLinkUp = 1'b0; EpLinkUp = 1'b0;
    #1;
    push(cyc, ev(0, 0, 0, 0, 0, 0), "async_clear_from_run");
    release_reset();
    push(23, ev(1, 1, 0, 0, 0, 2), "pre_expiry_edge23");
    push(24, ev(0, 0, 0, 1, 0, 4), "expiry_edge24");
    push(34, ev(0, 0, 0, 1, 0, 4), "timeout_sticky");
    push(35, ev(0, 0, 0, 1, 0, 0), "swreset_from_timeout");
    push(38, ev(0, 0, 0, 1, 0, 0), "hold_after_sw_release");
    push(39, ev(1, 0, 0, 1, 0, 1), "host_rel_after_sw");
    push(41, ev(1, 1, 0, 1, 0, 2), "ep_rel_after_sw");
    push(42, ev(1, 1, 1, 1, 0, 3), "run_fatal_kept");
    // The pending check just pushed at the old cycle is resolved first
    while (sb.size() != 0 && sb[0].tag == "async_clear_from_run") begin
      e = sb.pop_front(); n_checks++;
      if (obs !== e.vec) begin n_errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.vec); end
    end
    while (cyc < 42) begin
      if (cyc == 26) begin HostLinkUp = 1'b1; EpLinkUp = 1'b1; end
      SwReset = (cyc == 34);
      tick();
      while (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front(); n_checks++;
        if (obs !== e.vec) begin n_errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.vec); end
      end
    end
    SwReset = 1'b0;
    if (sb.size() != 0) begin n_checks++; n_errors++; $display("FAIL timeout_leftover: got %0d pending expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_race_swreset();
    notReset = 1'b0; SwReset = 1'b0; HostLinkUp = 1'b0; EpLinkUp = 1'b0;
    tick();
    release_reset();
    push(23, ev(1, 1, 0, 0, 0, 2), "race_pre_expiry");
    push(24, ev(1, 1, 1, 0, 0, 3), "race_link_wins");
    push(25, ev(1, 1, 0, 0, 1, 2), "race_drop");
    push(26, ev(1, 1, 1, 0, 1, 3), "race_recover");
    push(27, ev(0, 0, 0, 0, 1, 0), "swreset_in_run");
    push(31, ev(0, 0, 0, 0, 1, 0), "swreset_held");
    push(34, ev(0, 0, 0, 0, 1, 0), "hold_restart_edge3");
    push(35, ev(1, 0, 0, 0, 1, 1), "hold_restart_edge4");
    push(37, ev(1, 1, 0, 0, 1, 2), "ep_rel_restart");
    push(38, ev(1, 1, 1, 0, 1, 3), "run_restart");
    push(39, ev(1, 1, 0, 0, 2, 2), "second_drop");
    push(58, ev(1, 1, 0, 0, 2, 2), "wdog_after_drop_19");
    push(59, ev(0, 0, 0, 1, 2, 4), "wdog_after_drop_20");
    while (cyc < 59) begin
      if (cyc == 23) begin HostLinkUp = 1'b1; EpLinkUp = 1'b1; end
      if (cyc == 24) EpLinkUp = 1'b0;
      if (cyc == 25) EpLinkUp = 1'b1;
      if (cyc == 38) EpLinkUp = 1'b0;
      SwReset = (cyc >= 26) && (cyc < 31);
      tick();
      while (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front(); n_checks++;
        if (obs !== e.vec) begin n_errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.vec); end
      end
    end
    if (sb.size() != 0) begin n_checks++; n_errors++; $display("FAIL race_leftover: got %0d pending expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_async_reset();
    notReset = 1'b0; SwReset = 1'b0; HostLinkUp = 1'b0; EpLinkUp = 1'b0;
    tick();
    release_reset();
    push(5, ev(1, 0, 0, 0, 0, 1), "pre_async_rel_host");
    while (cyc < 5) begin
      tick();
      while (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front(); n_checks++;
        if (obs !== e.vec) begin n_errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.vec); end
      end
    end
    // Assert reset between edges; outputs must clear before the next rising edge
    #3;
    notReset = 1'b0;
    #1;
    push(cyc, ev(0, 0, 0, 0, 0, 0), "async_mid_rel_host");
    while (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front(); n_checks++;
      if (obs !== e.vec) begin n_errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.vec); end
    end
    tick();
    push(cyc, ev(0, 0, 0, 0, 0, 0), "async_held_across_edge");
    while (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front(); n_checks++;
      if (obs !== e.vec) begin n_errors++; $display("FAIL %s: got %h expected %h", e.tag, obs, e.vec); end
    end
    if (sb.size() != 0) begin n_checks++; n_errors++; $display("FAIL async_leftover: got %0d pending expected 0", sb.size()); sb.delete(); end
  endtask

  initial begin
    cyc = 0;
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_release();
    test_link_up();
    test_drops();
    test_timeout();
    test_race_swreset();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pcie_link_seq.md
PCIE_LINK_SEQ -- requirements
Module: pcie_link_seq

Interface
REQ-001 HOLD_CYCLES, 10, reset-release cycles before host reset is released (>=1).
REQ-002 EP_DELAY, 2, cycles between host and endpoint reset release (>=1).
REQ-003 TIMEOUT_CYCLES, 100000, link-training watchdog limit (>=1, <2^32).
REQ-004 Clk  input  1  free-running clock; all state changes on rising edge.
REQ-005 notReset  input  1  one clock; reset asynchronous, active-low.
REQ-006 SwReset  input  1  synchronous restart request, sampled every cycle.
REQ-007 HostLinkUp  input  1  host vhost reports link trained.
REQ-008 EpLinkUp  input  1  endpoint vhost reports link trained.
REQ-009 HostnReset  output  1  active-low reset to host node.
REQ-010 EpnReset  output  1  active-low reset to endpoint node.
REQ-011 LinkUp  output  1  both nodes trained and stable.
REQ-012 Fatal  output  1  sticky watchdog expiry flag.
REQ-013 LinkDropCount  output  8  saturating count of RUN-to-WAIT_LINK drops.
REQ-014 SeqState  output  3  current state encoding, for display/debug.

Function
REQ-015 States: HOLD, REL_HOST, WAIT_LINK, RUN, TIMEOUT; all outputs registered.
REQ-016 HOLD: counter increments each edge; at HOLD_CYCLES-th edge after reset release, HostnReset=1 and state=REL_HOST.
REQ-017 REL_HOST: EpnReset=1 on the EP_DELAY-th edge after entering; state=WAIT_LINK same edge.
REQ-018 Watchdog (32-bit) cleared on entering REL_HOST, increments each edge in REL_HOST and WAIT_LINK.
REQ-019 WAIT_LINK: HostLinkUp&EpLinkUp sampled 1 -> RUN, LinkUp=1 on that edge; watchdog cleared.
REQ-020 Watchdog reaching TIMEOUT_CYCLES in REL_HOST/WAIT_LINK -> TIMEOUT: Fatal=1, HostnReset=0, EpnReset=0, LinkUp=0.
REQ-021 Link-up and watchdog expiry on same edge: link-up wins, RUN entered, Fatal stays 0.
REQ-022 RUN: either link-up input sampled 0 -> WAIT_LINK, LinkUp=0, LinkDropCount+1 saturating at 255; watchdog cleared, nResets unchanged.
REQ-023 TIMEOUT is terminal except via notReset or SwReset; Fatal stays 1 until notReset.
REQ-024 SwReset=1 in any state -> HOLD next edge: both nResets=0, LinkUp=0, counters cleared; Fatal and LinkDropCount preserved.
REQ-025 SwReset held high keeps block in HOLD with counter cleared; release restarts full HOLD_CYCLES count.
REQ-026 Link-up inputs ignored in HOLD, REL_HOST and TIMEOUT.

Reset
REQ-027 notReset low asynchronously forces state=HOLD, HostnReset=0, EpnReset=0, LinkUp=0, Fatal=0, LinkDropCount=0, all counters 0.
REQ-028 Reset assertion mid-sequence (any state) has identical effect; no partial release glitches on nReset outputs.

Structure
REQ-029 Shared package pcie_link_seq_pkg holds the state enum/encodings and default HOLD/EP_DELAY/TIMEOUT constants.
REQ-030 One sub-module pcie_link_seq_cnt: 32-bit clearable counter with terminal-compare output, instanced for phase counter and watchdog.

Verification (HOLD_CYCLES=4, EP_DELAY=2, TIMEOUT_CYCLES=20)
REQ-031 Release notReset, links held 0 -> HostnReset=1 at edge 4, EpnReset=1 at edge 6, state WAIT_LINK.
REQ-032 Both link-ups high 5 cycles after EpnReset release -> LinkUp=1 on sampling edge, Fatal=0.
REQ-033 Links never up -> Fatal=1 and both nResets=0 on 20th watchdog edge after REL_HOST entry; remain so.
REQ-034 In RUN, EpLinkUp pulsed low 1 cycle, 300 times -> LinkUp drops each time, LinkDropCount=255.
REQ-035 Link-up on exact expiry edge -> RUN, Fatal=0; SwReset in RUN -> HOLD, nResets=0, LinkDropCount kept.
REQ-036 notReset asserted mid-REL_HOST -> all outputs reset immediately, without waiting for a clock edge.
